// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} div_state_t;

    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned DIV_CNT_W  = 5;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor magnitude, keep or restore.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {2'b00, dvsr_i};
        // A set top bit means the trial subtraction went negative.
        q_o     = ~diff[WIDTH+1];
        rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider: quotient to lo, remainder to hi, 34 cycles per op.
// Optional DIV_ZERO_EXC_EN adds the div_zero port and a one-cycle divide-by-zero exit.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef DIV_ZERO_EXC_EN
    ,
    output logic             div_zero
`endif
);

    div_state_t           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 sgn_quo_q, sgn_quo_d;
    logic                 sgn_rem_q, sgn_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    logic [WIDTH:0]       step_rem;
    logic                 step_q;

    // quo_q starts as |dividend| and fills with quotient bits from the right.
    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i  (rem_q),
        .bit_i  (quo_q[WIDTH-1]),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dz_d      = 1'b0;
                    dvsr_d    = divisor[WIDTH-1] ? -divisor : divisor;
                    quo_d     = dividend[WIDTH-1] ? -dividend : dividend;
                    rem_d     = '0;
                    sgn_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sgn_rem_d = dividend[WIDTH-1];
                    cnt_d     = '0;
                    state_d   = BUSY;
`ifdef DIV_ZERO_EXC_EN
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                if (cnt_q == DIV_CNT_W'(DIV_CYCLES - 1)) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                lo_d    = sgn_quo_q ? -quo_q : quo_q;
                hi_d    = sgn_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == BUSY) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

`ifdef DIV_ZERO_EXC_EN
    assign div_zero = dz_q;
`else
    logic unused_dz;
    assign unused_dz = dz_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit; honours DIV_ZERO_EXC_EN when defined.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef DIV_ZERO_EXC_EN
    logic        div_zero;
`endif

    div_unit #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
`ifdef DIV_ZERO_EXC_EN
        ,
        .div_zero (div_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] cur_lo = '0;
    logic [31:0] cur_hi = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.lat = 34;
        e.dz  = 1'b0;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_EXC_EN
            e.lat = 1;
            e.dz  = 1'b1;
            e.lo  = cur_lo;
            e.hi  = cur_hi;
`else
            e.lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
            e.hi = a;
`endif
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
        end else begin
            e.lo = 32'($signed(a) / $signed(b));
            e.hi = 32'($signed(a) % $signed(b));
        end
        return e;
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int repulse);
        exp_t e;
        int   cyc;
        int   nbusy;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Scramble operands so any resampling would corrupt the result.
        dividend = $urandom;
        divisor  = $urandom;
        cyc      = 1;
        nbusy    = 0;
        while (!done && cyc < 60) begin
            if (busy) nbusy++;
            if (cyc == 17) begin
                check_eq("lo_hold", lo, cur_lo);
                check_eq("hi_hold", hi, cur_hi);
            end
            if (repulse != 0 && cyc == repulse) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check_eq("latency", 32'(cyc), 32'(e.lat));
        check_eq("busy_cycles", 32'(nbusy), (e.lat == 34) ? 32'd33 : 32'd0);
        check_eq("busy_at_done", {31'd0, busy}, 32'd0);
        check_eq("lo", lo, e.lo);
        check_eq("hi", hi, e.hi);
`ifdef DIV_ZERO_EXC_EN
        check_eq("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
`endif
        cur_lo = e.lo;
        cur_hi = e.hi;
        @(posedge clk);
        #1;
        check_eq("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #12;
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_div(32'd100, 32'd7, 0);
        run_div(-32'sd7, 32'd2, 0);
        run_div(32'd7, -32'sd2, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(32'd5, 32'd0, 0);
        run_div(32'd1000, 32'd3, 10);

        // Abort an in-flight division with reset.
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("abort_hi", hi, 32'd0);
        check_eq("abort_lo", lo, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_done", {31'd0, done}, 32'd0);
        end
        reset_n = 1'b1;
        cur_lo  = '0;
        cur_hi  = '0;
        run_div(32'd9, 32'd3, 0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 5) b = -32'sd13;
            if (b == 32'd0) b = 32'd1;
            run_div(a, b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
